// File: rtl/clock_monitor_100khz_pkg.sv
// Shared definitions for the 100 kHz clock monitor.
// Holds the divider's nominal period and tolerance, the monitor state type
// and a saturating 8-bit increment helper.
package clock_monitor_100khz_pkg;

  localparam int unsigned EXPECTED_DEF = 10;
  localparam int unsigned TOL_DEF      = 1;

  typedef enum logic [1:0] {
    ST_LOST    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_e;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/clock_monitor_100khz_edge_sync.sv
// edge_sync: brings an asynchronous slow clock into the reference domain.
// Ports:
//   clk_i  - reference clock
//   rst_ni - asynchronous active-low reset
//   d_i    - asynchronous input
//   rise_o - combinational rise flag (high for one cycle after a synchronised 0->1)
module edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= d_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // An input already high at reset release shows up as one rise.
  assign rise_o = sync2_q & ~prev_q;

endmodule

// File: rtl/clock_monitor_100khz.sv
// clock_monitor_100khz: measures the period of the 100 kHz clock in 1 MHz
// cycles and tracks its health (LOST / ACQUIRE / LOCKED).
// Ports:
//   CLK_1MHZ_IN   - reference clock
//   RESET         - asynchronous active-low reset
//   CLK_100KHZ_IN - monitored clock (asynchronous)
//   RISE_TICK     - one-cycle pulse per detected rising edge
//   PERIOD_OUT    - last measured period
//   PERIOD_VALID  - one-cycle pulse when PERIOD_OUT updates
//   CLK_OK        - high while locked
//   CLK_LOST      - high while lost
//   ERR_COUNT     - saturating count of out-of-tolerance periods
module clock_monitor_100khz
  import clock_monitor_100khz_pkg::*;
#(
  parameter int unsigned EXPECTED   = EXPECTED_DEF,
  parameter int unsigned TOL        = TOL_DEF,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = 20,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK_1MHZ_IN,
  input  logic             RESET,
  input  logic             CLK_100KHZ_IN,
  output logic             RISE_TICK,
  output logic [CNT_W-1:0] PERIOD_OUT,
  output logic             PERIOD_VALID,
  output logic             CLK_OK,
  output logic             CLK_LOST,
  output logic [7:0]       ERR_COUNT
);

  localparam int unsigned GOOD_W = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0]  PER_MIN   = CNT_W'(EXPECTED - TOL);
  localparam logic [CNT_W-1:0]  PER_MAX   = CNT_W'(EXPECTED + TOL);
  localparam logic [CNT_W-1:0]  TO_VAL    = CNT_W'(TIMEOUT);
  localparam logic [GOOD_W-1:0] GOOD_LOCK = GOOD_W'(LOCK_COUNT);

  logic rise;

  edge_sync u_edge_sync (
    .clk_i  (CLK_1MHZ_IN),
    .rst_ni (RESET),
    .d_i    (CLK_100KHZ_IN),
    .rise_o (rise)
  );

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              meas_q, meas_d;
  logic [GOOD_W-1:0] good_cnt_q, good_cnt_d;
  logic [7:0]        err_q, err_d;
  logic [CNT_W-1:0]  period_q, period_d;
  logic              valid_d;
  logic              tick_q, valid_q, ok_q, lost_q;
  logic              good;

  assign good = (cnt_q >= PER_MIN) && (cnt_q <= PER_MAX);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    meas_d     = meas_q;
    good_cnt_d = good_cnt_q;
    err_d      = err_q;
    period_d   = period_q;
    valid_d    = 1'b0;
    if (rise) begin
      // A rise always restarts the count, so it takes priority over timeout.
      cnt_d  = CNT_W'(1);
      meas_d = 1'b1;
      if (meas_q) begin
        period_d = cnt_q;
        valid_d  = 1'b1;
      end
      case (state_q)
        ST_LOST: begin
          state_d    = ST_ACQUIRE;
          good_cnt_d = '0;
        end
        ST_ACQUIRE: begin
          if (good) begin
            good_cnt_d = good_cnt_q + 1'b1;
            if (good_cnt_q + 1'b1 == GOOD_LOCK) state_d = ST_LOCKED;
          end else begin
            good_cnt_d = '0;
            err_d      = sat_inc8(err_q);
          end
        end
        ST_LOCKED: begin
          if (!good) begin
            state_d    = ST_ACQUIRE;
            good_cnt_d = '0;
            err_d      = sat_inc8(err_q);
          end
        end
        default: state_d = ST_LOST;
      endcase
    end else begin
      if (meas_q && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
      if ((state_q != ST_LOST) && (cnt_q == TO_VAL)) begin
        state_d    = ST_LOST;
        meas_d     = 1'b0;
        good_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge CLK_1MHZ_IN or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_LOST;
      cnt_q      <= '0;
      meas_q     <= 1'b0;
      good_cnt_q <= '0;
      err_q      <= '0;
      period_q   <= '0;
      tick_q     <= 1'b0;
      valid_q    <= 1'b0;
      ok_q       <= 1'b0;
      lost_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      meas_q     <= meas_d;
      good_cnt_q <= good_cnt_d;
      err_q      <= err_d;
      period_q   <= period_d;
      tick_q     <= rise;
      valid_q    <= valid_d;
      // Decode from next state so the flags move on the same edge as the state.
      ok_q       <= (state_d == ST_LOCKED);
      lost_q     <= (state_d == ST_LOST);
    end
  end

  assign RISE_TICK    = tick_q;
  assign PERIOD_OUT   = period_q;
  assign PERIOD_VALID = valid_q;
  assign CLK_OK       = ok_q;
  assign CLK_LOST     = lost_q;
  assign ERR_COUNT    = err_q;

endmodule

// File: tb/tb_clock_monitor_100khz.sv
// Bench for clock_monitor_100khz: drives the slow clock as a sequence of
// periods, predicts each rise's outcome with an event-level model into a
// queue, and compares when RISE_TICK appears.
module tb_clock_monitor_100khz;

  localparam int EXP_P = 10;
  localparam int TOL_P = 1;
  localparam int LOCKN = 4;
  localparam int TMO   = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow = 1'b0;
  logic       rise_tick;
  logic [7:0] period_out;
  logic       period_valid;
  logic       clk_ok;
  logic       clk_lost;
  logic [7:0] err_count;

  clock_monitor_100khz #(
    .EXPECTED   (EXP_P),
    .TOL        (TOL_P),
    .LOCK_COUNT (LOCKN),
    .TIMEOUT    (TMO),
    .CNT_W      (8)
  ) dut (
    .CLK_1MHZ_IN   (clk),
    .RESET         (rst_n),
    .CLK_100KHZ_IN (slow),
    .RISE_TICK     (rise_tick),
    .PERIOD_OUT    (period_out),
    .PERIOD_VALID  (period_valid),
    .CLK_OK        (clk_ok),
    .CLK_LOST      (clk_lost),
    .ERR_COUNT     (err_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit valid;
    int period;
    bit ok;
    bit lost;
    int err;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Event-level reference: 0 lost, 1 acquire, 2 locked.
  bit m_meas;
  int m_state;
  int m_good;
  int m_err;
  int m_last;

  task automatic model_reset();
    m_meas  = 0;
    m_state = 0;
    m_good  = 0;
    m_err   = 0;
    m_last  = cyc;
  endtask

  task automatic model_rise();
    exp_t x;
    int   gap;
    bit   g;
    gap    = cyc - m_last;
    m_last = cyc;
    if (m_meas && gap > TMO) begin
      m_state = 0;
      m_meas  = 0;
      m_good  = 0;
    end
    x.valid  = m_meas;
    x.period = gap;
    g = (gap >= EXP_P - TOL_P) && (gap <= EXP_P + TOL_P);
    if (!m_meas) begin
      m_state = 1;
      m_good  = 0;
    end else if (g) begin
      if (m_state == 1) begin
        m_good++;
        if (m_good == LOCKN) m_state = 2;
      end
    end else begin
      m_state = 1;
      m_good  = 0;
      if (m_err < 255) m_err++;
    end
    m_meas   = 1;
    x.ok     = (m_state == 2);
    x.lost   = 0;
    x.err    = m_err;
    x.at_cyc = cyc + 3;
    sb.push_back(x);
  endtask

  // One rise now, next rise p cycles later.
  task automatic pulse(input int p);
    @(negedge clk);
    slow = 1'b1;
    model_rise();
    repeat (p / 2) @(negedge clk);
    slow = 1'b0;
    repeat (p - p / 2 - 1) @(negedge clk);
  endtask

  // One rise followed by a long silence; checks the exact timeout edge.
  task automatic pulse_lost();
    int c;
    @(negedge clk);
    c = cyc;
    slow = 1'b1;
    model_rise();
    while (cyc < c + 30) begin
      @(posedge clk);
      #1;
      if (cyc == c + 5) slow = 1'b0;
      if (cyc == c + 22) check("lost_before_timeout", clk_lost, 0);
      if (cyc == c + 23) begin
        check("lost_at_timeout", clk_lost, 1);
        check("ok_at_timeout", clk_ok, 0);
      end
    end
  endtask

  task automatic check_reset_vals(input string pfx);
    check({pfx, "_rise_tick"}, rise_tick, 0);
    check({pfx, "_period_out"}, period_out, 0);
    check({pfx, "_period_valid"}, period_valid, 0);
    check({pfx, "_clk_ok"}, clk_ok, 0);
    check({pfx, "_clk_lost"}, clk_lost, 1);
    check({pfx, "_err_count"}, err_count, 0);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    slow  = 1'b0;
    #1;
    check_reset_vals("async_rst");
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Scoreboard consumer.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && rise_tick) begin
        if (sb.size() == 0) begin
          check("unexpected_tick", 1, 0);
        end else begin
          e = sb.pop_front();
          check("tick_latency", cyc, e.at_cyc);
          check("period_valid", period_valid, e.valid);
          if (e.valid) check("period_out", period_out, e.period);
          check("clk_ok", clk_ok, e.ok);
          check("clk_lost", clk_lost, e.lost);
          check("err_count", err_count, e.err);
        end
      end else if (rst_n && period_valid) begin
        check("valid_without_tick", 1, 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running, expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    slow  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    repeat (5) @(negedge clk);

    // Clean clock: first rise unmeasured, lock after four good periods.
    repeat (6) pulse(10);
    check("locked_after_clean", clk_ok, 1);

    // One long period drops lock; four good periods relock.
    pulse(13);
    repeat (5) pulse(10);

    // Tolerance edges.
    pulse(9);
    pulse(11);
    pulse(8);
    pulse(12);
    repeat (6) pulse(10);

    // Stuck low while locked.
    pulse_lost();
    repeat (6) pulse(10);

    // Rise coincides with the timeout count.
    pulse(20);
    repeat (6) pulse(10);
    check("relocked_after_tmo_edge", clk_ok, 1);

    // Reset mid-lock, then a long run of bad periods.
    repeat (3) @(negedge clk);
    async_reset();
    repeat (4) @(negedge clk);
    repeat (301) pulse(8);
    repeat (10) @(negedge clk);
    check("err_saturated", err_count, 255);
    check("sb_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
